// File: rtl/segment_sampler_pkg.sv
// rtl/segment_sampler_pkg.sv - shared types and constants for the segment sampler
package segment_sampler_pkg;

   // Segment type codes; 0 marks an invalid segment
   localparam logic [1:0] EXPDOWN = 2'd1;
   localparam logic [1:0] EXPUP   = 2'd2;
   localparam logic [1:0] UNIFORM = 2'd3;

   // Galois LFSR shared by the random-choice blocks
   localparam int                LFSR_W            = 32;
   localparam logic [LFSR_W-1:0] LFSR_TAPS         = 32'h8020_0003;
   localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 32'h0000_0001;

   // Uniform rejections tolerated before the folded value is forced out
   localparam logic [3:0] RETRY_LIMIT = 4'd15;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETUP    = 3'd1,
      ST_DRAW_UNI = 3'd2,
      ST_DRAW_EXP = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

endpackage

// File: rtl/sampler_lfsr.sv
// rtl/sampler_lfsr.sv - 32-bit Galois LFSR with seed load and step enable
module sampler_lfsr
   import segment_sampler_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              step,
   output logic [LFSR_W-1:0] value
);

   // Load wins over step; an all-zero seed would lock the register, so it becomes 1
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         value <= LFSR_SEED_DEFAULT;
      end else if (load) begin
         value <= (seed == '0) ? LFSR_SEED_DEFAULT : seed;
      end else if (step) begin
         value <= (value >> 1) ^ (value[0] ? LFSR_TAPS : '0);
      end
   end

endmodule

// File: rtl/segment_sampler.sv
// rtl/segment_sampler.sv - draws one sample from a uniform or exponential range segment
module segment_sampler
   import segment_sampler_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic             in_clock,
   input  logic             in_reset_n,
   input  logic             in_seed_load,
   input  logic [WIDTH:0]   in_seed,
   input  logic             in_valid,
   output logic             out_ready,
   input  logic [1:0]       in_segment_type,
   input  logic [WIDTH-1:0] in_segment_from,
   input  logic [WIDTH-1:0] in_segment_to,
   output logic             out_valid,
   input  logic             in_ready,
   output logic [WIDTH-1:0] out_sample,
   output logic             out_error
);

   state_t            state;
   logic [1:0]        seg_type;
   logic [WIDTH-1:0]  seg_from;
   logic [WIDTH-1:0]  seg_to;
   logic [WIDTH:0]    span;
   logic [WIDTH:0]    mask;
   logic [WIDTH:0]    k;
   logic [3:0]        retry;

   logic [LFSR_W-1:0] lfsr_value;
   logic [LFSR_W-1:0] seed_word;
   logic              lfsr_load;
   logic              lfsr_step;
   logic              unused_seed_msb;

   logic [WIDTH:0]    from_ext;
   logic [WIDTH:0]    to_ext;
   logic [WIDTH:0]    span_calc;
   logic [WIDTH:0]    mask_calc;
   logic [WIDTH:0]    r_ext;
   logic [WIDTH:0]    v;
   logic [WIDTH:0]    k_next;
   logic              seg_bad;
   logic [WIDTH-1:0]  uni_hit;
   logic [WIDTH-1:0]  uni_wrap;
   logic [WIDTH-1:0]  exp_down;
   logic [WIDTH-1:0]  exp_up;

   assign seed_word       = LFSR_W'(in_seed[WIDTH-1:0]);
   assign unused_seed_msb = in_seed[WIDTH];
   assign lfsr_load       = in_seed_load && (state == ST_IDLE);
   assign lfsr_step       = (state == ST_DRAW_UNI) || (state == ST_DRAW_EXP);
   assign out_ready       = (state == ST_IDLE);

   sampler_lfsr u_lfsr (
      .clock   (in_clock),
      .reset_n (in_reset_n),
      .load    (lfsr_load),
      .seed    (seed_word),
      .step    (lfsr_step),
      .value   (lfsr_value)
   );

   // Bounds are sign-extended by one bit so span and offsets never overflow
   assign from_ext  = {seg_from[WIDTH-1], seg_from};
   assign to_ext    = {seg_to[WIDTH-1], seg_to};
   assign span_calc = to_ext - from_ext + (WIDTH+1)'(1);
   assign seg_bad   = (seg_type == 2'd0) || ($signed(seg_to) < $signed(seg_from));
   assign r_ext     = (WIDTH+1)'(lfsr_value);
   assign v         = r_ext & mask;
   assign k_next    = k + (WIDTH+1)'(1);
   assign uni_hit   = WIDTH'(from_ext + v);
   assign uni_wrap  = WIDTH'(from_ext + (v - span));
   assign exp_down  = WIDTH'(from_ext + k);
   assign exp_up    = WIDTH'(to_ext - k);

   // Smear the highest set bit of L-1 downwards to form the rejection mask
   always_comb begin
      mask_calc = span_calc - (WIDTH+1)'(1);
      for (int s = 1; s <= WIDTH; s = s * 2) begin
         mask_calc = mask_calc | (mask_calc >> s);
      end
   end

   // Sampler control: capture, setup, draw loops and output hold
   always_ff @(posedge in_clock or negedge in_reset_n) begin
      if (!in_reset_n) begin
         state      <= ST_IDLE;
         seg_type   <= '0;
         seg_from   <= '0;
         seg_to     <= '0;
         span       <= '0;
         mask       <= '0;
         k          <= '0;
         retry      <= '0;
         out_valid  <= 1'b0;
         out_sample <= '0;
         out_error  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  seg_type <= in_segment_type;
                  seg_from <= in_segment_from;
                  seg_to   <= in_segment_to;
                  state    <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               span  <= span_calc;
               mask  <= mask_calc;
               k     <= '0;
               retry <= '0;
               if (seg_bad) begin
                  out_sample <= seg_from;
                  out_error  <= 1'b1;
                  out_valid  <= 1'b1;
                  state      <= ST_DONE;
               end else if (span_calc == (WIDTH+1)'(1)) begin
                  out_sample <= seg_from;
                  out_error  <= 1'b0;
                  out_valid  <= 1'b1;
                  state      <= ST_DONE;
               end else if (seg_type == UNIFORM) begin
                  state <= ST_DRAW_UNI;
               end else begin
                  state <= ST_DRAW_EXP;
               end
            end
            ST_DRAW_UNI: begin
               // v < 2L always holds, so folding by one span stays in range
               if (v < span) begin
                  out_sample <= uni_hit;
                  out_error  <= 1'b0;
                  out_valid  <= 1'b1;
                  state      <= ST_DONE;
               end else if (retry == RETRY_LIMIT) begin
                  out_sample <= uni_wrap;
                  out_error  <= 1'b0;
                  out_valid  <= 1'b1;
                  state      <= ST_DONE;
               end else begin
                  retry <= retry + 4'd1;
               end
            end
            ST_DRAW_EXP: begin
               // Wrapping k at L restarts the walk, giving an exact truncated geometric
               if (lfsr_value[0]) begin
                  k <= (k_next == span) ? '0 : k_next;
               end else begin
                  out_sample <= (seg_type == EXPUP) ? exp_up : exp_down;
                  out_error  <= 1'b0;
                  out_valid  <= 1'b1;
                  state      <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (in_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/segment_sampler.md
# segment_sampler

Draws one signed sample value from a single range segment (type, from, to) as produced by the segment selector, closing the MCMC variable-update loop. The segment type sets the distribution: uniform, exponential-down (mass halving away from `from`), or exponential-up (mass halving away from `to`). It sits directly downstream of segment selection. It accepts one segment per valid/ready handshake and returns one sample per valid/ready handshake.

## Interface
- `WIDTH`, 32, data width of segment bounds and of the sample.
- `in_clock`  in  1  system clock; all state changes on its rising edge.
- `in_reset_n`  in  1  asynchronous, active-low reset.
- `in_seed_load`  in  1  loads `in_seed` into the LFSR (honoured in IDLE only).
- `in_seed`  in  WIDTH+1  seed value; only bits [WIDTH-1:0] are used; a zero value is replaced by 1.
- `in_valid`  in  1  segment descriptor valid.
- `out_ready`  out  1  block can accept a segment; equals (state == IDLE).
- `in_segment_type`  in  2  1 = EXPDOWN, 2 = EXPUP, 3 = UNIFORM, 0 = invalid.
- `in_segment_from`  in  WIDTH signed  lower bound, inclusive.
- `in_segment_to`  in  WIDTH signed  upper bound, inclusive.
- `out_valid`  out  1  sample valid; held until it is consumed.
- `in_ready`  in  1  downstream consumes the sample.
- `out_sample`  out  WIDTH signed  drawn value.
- `out_error`  out  1  set with `out_valid` when the type is 0 or `to < from`.

## Operation
- States: IDLE, SETUP, DRAW_UNI, DRAW_EXP, DONE.
- IDLE:
  - Seed load has priority. If `in_seed_load` and `in_valid` are both high, the new seed is loaded and the segment is captured in the same cycle; the draw uses the new seed.
  - If `in_valid` is high, capture type, from and to, then go to SETUP.
- SETUP (1 cycle):
  - Compute span L = to − from + 1 in WIDTH+1 unsigned bits.
  - Compute mask = (L−1) with all bits below its MSB set.
  - Error case (`to < from` or type 0): load sample = from, set error, go to DONE.
  - L = 1: sample = from, go to DONE.
  - Otherwise, UNIFORM goes to DRAW_UNI; EXPDOWN and EXPUP go to DRAW_EXP with k = 0.
- LFSR:
  - 32-bit Galois, taps 0x80200003.
  - Steps exactly once per DRAW_* cycle and never otherwise.
  - Each draw uses the pre-step value r.
- DRAW_UNI:
  - Compute v = r & mask.
  - If v < L, accept: sample = from + v.
  - Otherwise increment the retry counter and stay in DRAW_UNI.
  - After 15 rejections, force-accept sample = from + (v − L). This is valid because v < 2L.
  - Go to DONE on accept.
- DRAW_EXP:
  - If r[0] = 1, increment k.
  - If r[0] = 1 and k+1 reaches L, reset k to 0 and continue. This rejection gives the exact truncated geometric distribution.
  - If r[0] = 0, stop: EXPDOWN sample = from + k; EXPUP sample = to − k. Go to DONE.
- DONE:
  - `out_valid` = 1; `out_sample` and `out_error` stay stable.
  - When `in_ready` is high, go to IDLE.
- Arithmetic: from + offset and to − offset are computed in WIDTH+1 bits. The result always lies in [from, to], so no overflow is possible.

## Timing
- Reset values: state IDLE, LFSR 0x00000001, `out_valid` 0, `out_sample` 0, `out_error` 0, k and retry counter 0. `out_ready` is 1 after reset because it is derived from the state.
- Reset asserted mid-draw aborts immediately. Any pending sample is lost, and the seed returns to 1.
- Latency is counted from the capture edge to the first cycle `out_valid` is high:
  - Error or L = 1: 2 cycles.
  - Uniform, first draw accepted: 3 cycles.
  - Each uniform rejection: +1 cycle.
  - Exponential: 3 + (number of 1-bits consumed) cycles.
- Throughput: the next segment can be captured in the cycle after the sample is consumed.
- `out_ready` is low in every state except IDLE. `in_valid` in other states is ignored and not captured.

## Structure
- `segment_sampler_pkg` holds:
  - type constants EXPDOWN = 2'd1, EXPUP = 2'd2, UNIFORM = 2'd3;
  - the state encoding;
  - the LFSR tap constant;
  - the retry limit of 15.
- Sub-module `sampler_lfsr`, holding the Galois LFSR, with inputs clock, reset_n, load, seed and step, and output value. It is reusable by the other random-choice blocks.

## Test plan
- Seed 1, UNIFORM from = 5, to = 5 -> `out_sample` = 5, `out_error` = 0, `out_valid` at capture+2, LFSR not stepped.
- UNIFORM from = −4, to = 3, 8000 samples -> all values in [−4, 3]; each bucket count within 1000 ± 10%.
- EXPDOWN from = 0, to = 7, 8000 samples -> counts roughly halve per step (0 ≈ 4016, 1 ≈ 2008, ...), none above 7. EXPUP 0..7 gives the mirrored histogram, peaking at 7.
- Type 0, or from = 10 with to = 9 -> `out_error` = 1, `out_sample` = 10, latency 2.
- Hold `in_ready` = 0 for 20 cycles in DONE -> `out_valid`/`out_sample` stable, `out_ready` = 0, a new `in_valid` is ignored. Release -> IDLE, next segment accepted.
- Assert `in_reset_n` low during DRAW_EXP -> `out_valid` 0 asynchronously. After release, seed load plus the same segment reproduces the bit-exact sample sequence of a fresh run.
